l2_responder: RTL and testbench

L2_RESPONDER -- requirements
Module: l2_responder

---
 rtl/l2_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_l2_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_responder.sv
// Direct-mapped, one-word-per-line write-back L2 responder with write-allocate (no fill on
// write miss), a single backing-memory port and saturating hit/miss counters.
module l2_responder #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  inout  wire  [31:0] io_data,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic [15:0] o_hit_cnt,
  output logic [15:0] o_miss_cnt
);

  localparam int unsigned TagW = 30 - IDX_W;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StEvict,
    StFill,
    StResp
  } state_e;

  state_e            r_state, w_state_d;
  logic              r_stall;
  logic              r_mem_req, w_mem_req_d;
  logic              r_mem_we, w_mem_we_d;
  logic [31:0]       r_mem_addr, w_mem_addr_d;
  logic [31:0]       r_mem_wdata, w_mem_wdata_d;
  logic              r_rd_valid, w_rd_valid_d;
  logic [31:0]       r_rd_data, w_rd_data_d;
  logic [15:0]       r_hit_cnt, w_hit_cnt_d;
  logic [15:0]       r_miss_cnt, w_miss_cnt_d;

  // Latched L1 request
  logic [IDX_W-1:0]  r_req_idx;
  logic [TagW-1:0]   r_req_tag;
  logic              r_req_we;
  logic [31:0]       r_req_wdata;

  // Line storage
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TagW-1:0]   r_tag  [LINES];
  logic [31:0]       r_line [LINES];

  logic              w_capture;
  logic              w_hit;
  logic              w_victim_dirty;
  logic              w_mem_ack;
  logic              w_line_wr;
  logic              w_line_dirty;
  logic [31:0]       w_line_data;
  logic [31:0]       w_fill_addr;
  logic              w_unused_addr;

  assign w_unused_addr  = ^i_addr[1:0];
  assign w_hit          = r_valid[r_req_idx] && (r_tag[r_req_idx] == r_req_tag);
  assign w_victim_dirty = r_valid[r_req_idx] && r_dirty[r_req_idx];
  // An ack only counts while a transfer is actually outstanding
  assign w_mem_ack      = i_mem_ack && r_mem_req;
  assign w_fill_addr    = {r_req_tag, r_req_idx, 2'b00};

  always_comb begin
    w_state_d     = r_state;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_rd_valid_d  = r_rd_valid;
    w_rd_data_d   = r_rd_data;
    w_hit_cnt_d   = r_hit_cnt;
    w_miss_cnt_d  = r_miss_cnt;
    w_capture     = 1'b0;
    w_line_wr     = 1'b0;
    w_line_dirty  = 1'b1;
    w_line_data   = r_req_wdata;

    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          w_capture = 1'b1;
          w_state_d = StLookup;
        end
      end

      StLookup: begin
        if (w_hit) begin
          w_hit_cnt_d = (r_hit_cnt == 16'hFFFF) ? r_hit_cnt : r_hit_cnt + 16'd1;
          w_state_d   = StResp;
          if (r_req_we) begin
            w_rd_data_d = r_line[r_req_idx];
          end else begin
            w_line_wr = 1'b1;
          end
        end else begin
          w_miss_cnt_d = (r_miss_cnt == 16'hFFFF) ? r_miss_cnt : r_miss_cnt + 16'd1;
          if (w_victim_dirty) begin
            w_state_d     = StEvict;
            w_mem_req_d   = 1'b1;
            w_mem_we_d    = 1'b1;
            w_mem_addr_d  = {r_tag[r_req_idx], r_req_idx, 2'b00};
            w_mem_wdata_d = r_line[r_req_idx];
          end else if (r_req_we) begin
            w_state_d    = StFill;
            w_mem_req_d  = 1'b1;
            w_mem_we_d   = 1'b0;
            w_mem_addr_d = w_fill_addr;
          end else begin
            w_state_d = StResp;
            w_line_wr = 1'b1;
          end
        end
      end

      StEvict: begin
        if (w_mem_ack) begin
          w_mem_req_d = 1'b0;
          if (r_req_we) begin
            // Request drops for one cycle so address/direction never change under mem_req
            w_state_d    = StFill;
            w_mem_we_d   = 1'b0;
            w_mem_addr_d = w_fill_addr;
          end else begin
            w_state_d = StResp;
            w_line_wr = 1'b1;
          end
        end
      end

      StFill: begin
        if (w_mem_ack) begin
          w_mem_req_d  = 1'b0;
          w_state_d    = StResp;
          w_line_wr    = 1'b1;
          w_line_dirty = 1'b0;
          w_line_data  = i_mem_rdata;
          w_rd_data_d  = i_mem_rdata;
        end else begin
          w_mem_req_d = 1'b1;
        end
      end

      StResp: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    if ((w_state_d == StResp) && (r_state != StResp)) begin
      w_rd_valid_d = r_req_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_stall     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_req_idx   <= '0;
      r_req_tag   <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_stall     <= (w_state_d == StLookup) || (w_state_d == StEvict) ||
                     (w_state_d == StFill);
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_rd_valid  <= w_rd_valid_d;
      r_rd_data   <= w_rd_data_d;
      r_hit_cnt   <= w_hit_cnt_d;
      r_miss_cnt  <= w_miss_cnt_d;
      if (w_capture) begin
        r_req_idx   <= i_addr[IDX_W+1:2];
        r_req_tag   <= i_addr[31:IDX_W+2];
        r_req_we    <= i_we;
        r_req_wdata <= io_data;
      end
      if (w_line_wr) begin
        r_valid[r_req_idx] <= 1'b1;
        r_dirty[r_req_idx] <= w_line_dirty;
        r_tag[r_req_idx]   <= r_req_tag;
        r_line[r_req_idx]  <= w_line_data;
      end
    end
  end

  assign io_data     = (r_rd_valid && !r_stall && i_we) ? r_rd_data : 'z;
  assign o_stall     = r_stall;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_l2_responder.sv
// Bench for l2_responder: directed vector table, reset/saturation/ignore sequences, and random
// traffic checked against a line-level cache model with its own reference memory.
module tb_l2_responder;

  localparam int unsigned LINES = 16;
  localparam int unsigned IDX_W = 4;

  logic        clk = 1'b0;
  logic        rst, req, we, mem_ack;
  logic [31:0] addr, mem_rdata;
  wire  [31:0] data;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] hit_cnt, miss_cnt;

  assign data = tb_drv ? tb_wdata : 32'hzzzz_zzzz;
  always #5 clk = ~clk;

  l2_responder #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_addr     (addr),
    .i_we       (we),
    .io_data    (data),
    .o_stall    (stall),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_ack  (mem_ack),
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cur_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (txn %0d): got %h, expected %h", name, cur_txn, act, exp);
  endtask

  // Memory seen by the DUT, and the model's own reference memory
  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Observations of one transaction
  int          ev_n, fill_n, stall_cyc;
  logic [31:0] ev_addr, ev_data, fill_addr, rd_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One L1 transaction; services memory with `dly` wait cycles per transfer
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input bit pulse);
    int          wait_c;
    bit          pulsed, cap_v;
    logic [31:0] cap_a, cap_d;
    logic        cap_we;
    ev_n = 0; fill_n = 0; stall_cyc = 0; wait_c = 0; pulsed = 0; cap_v = 0;
    cap_a = '0; cap_d = '0; cap_we = 1'b0;
    req = 1'b1; we = w; addr = a; tb_drv = !w; tb_wdata = d;
    tick();
    req = 1'b0;
    for (int c = 0; c < 100 && stall; c++) begin
      mem_ack = 1'b0;
      stall_cyc++;
      if (mem_req) begin
        if (cap_v) begin
          chk("mem_addr_stable", mem_addr, cap_a);
          chk("mem_we_stable", {31'd0, mem_we}, {31'd0, cap_we});
          if (cap_we) chk("mem_wdata_stable", mem_wdata, cap_d);
        end else begin
          cap_v = 1; cap_a = mem_addr; cap_d = mem_wdata; cap_we = mem_we;
        end
        if (pulse && !pulsed && !mem_we) begin
          req = 1'b1;
          pulsed = 1;
        end
        if (wait_c >= dly) begin
          mem_ack = 1'b1; wait_c = 0; cap_v = 0;
          if (mem_we) begin
            ev_n++; ev_addr = mem_addr; ev_data = mem_wdata; mem[mem_addr] = mem_wdata;
          end else begin
            fill_n++; fill_addr = mem_addr; mem_rdata = mem_rd(mem_addr);
          end
        end else begin
          wait_c++;
        end
      end
      tick();
      req = 1'b0;
    end
    mem_ack = 1'b0;
    chk("stall_released", {31'd0, stall}, 32'd0);
    rd_val = data;
    tick();
    tb_drv = 1'b0;
  endtask

  // Line-level model
  logic              m_valid [LINES];
  logic              m_dirty [LINES];
  logic [31:0]       m_tag   [LINES];
  logic [31:0]       m_data  [LINES];
  int                m_hit, m_miss;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; m_data[i] = 0;
    end
    m_hit = 0; m_miss = 0;
  endtask

  task automatic model_check(input logic w, input logic [31:0] a, input logic [31:0] d);
    int          i;
    logic [31:0] t, va, val;
    i = int'((a >> 2) % LINES);
    t = a >> (IDX_W + 2);
    if (m_valid[i] && m_tag[i] == t) begin
      if (m_hit < 65535) m_hit++;
      chk("rnd_ev_n", ev_n, 0);
      chk("rnd_fill_n", fill_n, 0);
      chk("rnd_hit_stall", stall_cyc, 1);
      if (w) chk("rnd_hit_rdata", rd_val, m_data[i]);
      else begin m_data[i] = d; m_dirty[i] = 1; end
    end else begin
      if (m_miss < 65535) m_miss++;
      if (m_valid[i] && m_dirty[i]) begin
        va = (m_tag[i] << (IDX_W + 2)) | (i << 2);
        ref_mem[va] = m_data[i];
        chk("rnd_ev_n", ev_n, 1);
        chk("rnd_ev_addr", ev_addr, va);
        chk("rnd_ev_data", ev_data, m_data[i]);
      end else begin
        chk("rnd_ev_n", ev_n, 0);
      end
      m_valid[i] = 1; m_tag[i] = t;
      if (w) begin
        val = ref_rd(a & ~32'd3);
        chk("rnd_fill_n", fill_n, 1);
        chk("rnd_fill_addr", fill_addr, a & ~32'd3);
        chk("rnd_miss_rdata", rd_val, val);
        m_data[i] = val; m_dirty[i] = 0;
      end else begin
        chk("rnd_fill_n", fill_n, 0);
        m_data[i] = d; m_dirty[i] = 1;
      end
    end
    chk("rnd_hit_cnt", {16'd0, hit_cnt}, m_hit);
    chk("rnd_miss_cnt", {16'd0, miss_cnt}, m_miss);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    int          ev;
    logic [31:0] ev_addr;
    logic [31:0] ev_data;
    int          fill;
    logic [31:0] fill_addr;
    logic [31:0] rdata;
    int          scyc;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 32'h40,  32'h0,        3, 0, 32'h0,  32'h0,        1, 32'h40, 32'hDEADBEEF,
                -1, 16'd0, 16'd1};
    vecs[1] = '{1'b1, 32'h40,  32'h0,        0, 0, 32'h0,  32'h0,        0, 32'h0,  32'hDEADBEEF,
                1,  16'd1, 16'd1};
    vecs[2] = '{1'b0, 32'h40,  32'hAAAA0040, 0, 0, 32'h0,  32'h0,        0, 32'h0,  32'h0,
                1,  16'd2, 16'd1};
    vecs[3] = '{1'b1, 32'h80,  32'h0,        2, 1, 32'h40, 32'hAAAA0040, 1, 32'h80, 32'h0BAD0080,
                -1, 16'd2, 16'd2};
    vecs[4] = '{1'b0, 32'h104, 32'h12345678, 0, 0, 32'h0,  32'h0,        0, 32'h0,  32'h0,
                1,  16'd2, 16'd3};
    vecs[5] = '{1'b1, 32'h104, 32'h0,        0, 0, 32'h0,  32'h0,        0, 32'h0,  32'h12345678,
                1,  16'd3, 16'd3};
    vecs[6] = '{1'b1, 32'h40,  32'h0,        1, 0, 32'h0,  32'h0,        1, 32'h40, 32'hAAAA0040,
                -1, 16'd3, 16'd4};

    rst = 1'b0; req = 1'b0; we = 1'b1; addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    tb_drv = 1'b0; tb_wdata = '0;
    mem[32'h40] = 32'hDEADBEEF;
    mem[32'h80] = 32'h0BAD0080;
    tick();
    do_reset();

    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      cur_txn = v;
      do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].dly, 0);
      chk("vec_ev_n", ev_n, vecs[v].ev);
      if (vecs[v].ev != 0) begin
        chk("vec_ev_addr", ev_addr, vecs[v].ev_addr);
        chk("vec_ev_data", ev_data, vecs[v].ev_data);
      end
      chk("vec_fill_n", fill_n, vecs[v].fill);
      if (vecs[v].fill != 0) chk("vec_fill_addr", fill_addr, vecs[v].fill_addr);
      if (vecs[v].we) chk("vec_rdata", rd_val, vecs[v].rdata);
      if (vecs[v].scyc >= 0) chk("vec_stall_cycles", stall_cyc, vecs[v].scyc);
      chk("vec_hit_cnt", {16'd0, hit_cnt}, {16'd0, vecs[v].hits});
      chk("vec_miss_cnt", {16'd0, miss_cnt}, {16'd0, vecs[v].misses});
    end

    // Reset while FILL is outstanding
    cur_txn = 100;
    do_reset();
    req = 1'b1; we = 1'b1; addr = 32'h200;
    tick();
    req = 1'b0;
    tick();
    chk("fill_mem_req", {31'd0, mem_req}, 32'd1);
    chk("fill_mem_we", {31'd0, mem_we}, 32'd0);
    chk("fill_mem_addr", mem_addr, 32'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    do_req(1'b1, 32'h200, 32'h0, 1, 0);
    chk("reread_fill_n", fill_n, 1);
    chk("reread_rdata", rd_val, dflt(32'h200));
    chk("reread_miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // Hit counter saturation, preloaded just below the limit
    cur_txn = 200;
    force dut.r_hit_cnt = 16'hFFFE;
    #1;
    release dut.r_hit_cnt;
    tick();
    do_req(1'b1, 32'h200, 32'h0, 0, 0);
    chk("sat_hit_cnt_a", {16'd0, hit_cnt}, 32'h0000FFFF);
    do_req(1'b1, 32'h200, 32'h0, 0, 0);
    chk("sat_hit_cnt_b", {16'd0, hit_cnt}, 32'h0000FFFF);
    chk("sat_miss_cnt", {16'd0, miss_cnt}, 32'd1);

    // req pulsed during FILL must not start another transaction
    cur_txn = 300;
    do_req(1'b1, 32'h300, 32'h0, 2, 1);
    chk("pulse_fill_n", fill_n, 1);
    for (int c = 0; c < 3; c++) begin
      chk("pulse_no_stall", {31'd0, stall}, 32'd0);
      chk("pulse_no_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    chk("pulse_miss_cnt", {16'd0, miss_cnt}, 32'd2);
    chk("pulse_hit_cnt", {16'd0, hit_cnt}, 32'h0000FFFF);

    // Random traffic against the model
    do_reset();
    model_reset();
    mem.delete();
    ref_mem.delete();
    for (int n = 0; n < 200; n++) begin
      logic        w;
      logic [31:0] a, d, tv;
      int          tsel;
      cur_txn = 1000 + n;
      w = 1'($urandom_range(0, 1));
      tsel = int'($urandom_range(0, 3));
      tv = (tsel == 3) ? 32'h03FF_FFFF : 32'(tsel);
      a = (tv << (IDX_W + 2)) | (32'($urandom_range(0, LINES - 1)) << 2) |
          32'($urandom_range(0, 3));
      d = $urandom;
      do_req(w, a, d, int'($urandom_range(0, 3)), 0);
      model_check(w, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
